// File: rtl/zii_ide_pkg.sv
// Shared definitions for the Zorro II IDE cycle controller: FSM states,
// address regions and the address bits that select them.
package zii_ide_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROM_WAIT,
        ST_IDE_SETUP,
        ST_IDE_STROBE,
        ST_IDE_ACK,
        ST_IDE_HOLD,
        ST_WAIT_END
    } state_t;

    typedef enum logic [1:0] {
        REG_ROM,
        REG_CS0,
        REG_CS1
    } region_t;

    localparam int ROM_SEL_BIT = 15;
    localparam int CS_SEL_BIT  = 12;
    localparam int DA_LSB      = 2;

    // A[14:13] never reach here, so they alias within each region.
    function automatic region_t decode_region(input logic rom_sel, input logic cs_sel);
        if (!rom_sel)
            return REG_ROM;
        else if (cs_sel)
            return REG_CS1;
        else
            return REG_CS0;
    endfunction

endpackage

// File: rtl/zii_ide_cycle_ctrl_sync2.sv
// Two-flop synchroniser for an active-low CPU strobe; resets to the
// inactive (high) level so no phantom cycle is seen after reset.
module sync2 (
    input  logic CLK,
    input  logic RESET_n,
    input  logic d,
    output logic q
);

    logic meta_p0;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            meta_p0 <= 1'b1;
            q       <= 1'b1;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/zii_ide_cycle_ctrl.sv
// Zorro II access controller for the IDE card: decodes the assigned 64 KB
// window into boot ROM and ATA PIO register cycles and terminates them.
module zii_ide_cycle_ctrl
    import zii_ide_pkg::*;
#(
    parameter int unsigned SETUP_CLKS    = 2,
    parameter int unsigned STROBE_CLKS   = 5,
    parameter int unsigned HOLD_CLKS     = 1,
    parameter int unsigned ROM_WAIT_CLKS = 3
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        AS_CPU_n,
    input  logic        DS_n,
    input  logic        RW_n,
    input  logic [23:1] A,
    input  logic [7:0]  BASE_IDE,
    input  logic        IDE_CONFIGURED_n,
    output logic        DTACK_n,
    output logic        ROM_OE_n,
    output logic        IDE_CS0_n,
    output logic        IDE_CS1_n,
    output logic [2:0]  IDE_DA,
    output logic        IDE_DIOR_n,
    output logic        IDE_DIOW_n,
    output logic        IDE_BUF_OE_n,
    output logic        IDE_BUF_DIR
);

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CLKS - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CLKS - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CLKS - 1);
    localparam logic [3:0] ROM_LD    = 4'(ROM_WAIT_CLKS - 1);

    logic    as_s;
    logic    ds_s;
    logic    hit;
    region_t region;
    state_t  state;
    logic [3:0] cnt;
    logic    rw_r;
    logic    unused_a;

    sync2 u_sync_as (.CLK(CLK), .RESET_n(RESET_n), .d(AS_CPU_n), .q(as_s));
    sync2 u_sync_ds (.CLK(CLK), .RESET_n(RESET_n), .d(DS_n),     .q(ds_s));

    assign hit      = !IDE_CONFIGURED_n && (A[23:16] == BASE_IDE) && !as_s && !ds_s;
    assign region   = decode_region(A[ROM_SEL_BIT], A[CS_SEL_BIT]);
    assign unused_a = ^{A[14:13], A[11:5], A[1]};

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state        <= ST_IDLE;
            cnt          <= 4'd0;
            rw_r         <= 1'b1;
            DTACK_n      <= 1'b1;
            ROM_OE_n     <= 1'b1;
            IDE_CS0_n    <= 1'b1;
            IDE_CS1_n    <= 1'b1;
            IDE_DA       <= 3'd0;
            IDE_DIOR_n   <= 1'b1;
            IDE_DIOW_n   <= 1'b1;
            IDE_BUF_OE_n <= 1'b1;
            IDE_BUF_DIR  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hit) begin
                        rw_r <= RW_n;
                        if (region == REG_ROM) begin
                            if (RW_n) begin
                                ROM_OE_n <= 1'b0;
                                cnt      <= ROM_LD;
                                state    <= ST_ROM_WAIT;
                            end else begin
                                DTACK_n <= 1'b0;
                                state   <= ST_WAIT_END;
                            end
                        end else begin
                            // The registered chip selects carry the region to cycle end.
                            IDE_CS0_n    <= (region != REG_CS0);
                            IDE_CS1_n    <= (region != REG_CS1);
                            IDE_DA       <= A[DA_LSB +: 3];
                            IDE_BUF_OE_n <= 1'b0;
                            IDE_BUF_DIR  <= RW_n;
                            cnt          <= SETUP_LD;
                            state        <= ST_IDE_SETUP;
                        end
                    end
                end
                ST_ROM_WAIT: begin
                    if (as_s) begin
                        ROM_OE_n <= 1'b1;
                        state    <= ST_IDLE;
                    end else if (cnt == 4'd0) begin
                        DTACK_n <= 1'b0;
                        state   <= ST_WAIT_END;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_IDE_SETUP: begin
                    if (as_s) begin
                        cnt   <= HOLD_LD;
                        state <= ST_IDE_HOLD;
                    end else if (cnt == 4'd0) begin
                        IDE_DIOR_n <= !rw_r;
                        IDE_DIOW_n <= rw_r;
                        cnt        <= STROBE_LD;
                        state      <= ST_IDE_STROBE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_IDE_STROBE: begin
                    if (as_s) begin
                        IDE_DIOR_n <= 1'b1;
                        IDE_DIOW_n <= 1'b1;
                        cnt        <= HOLD_LD;
                        state      <= ST_IDE_HOLD;
                    end else if (cnt == 4'd0) begin
                        DTACK_n <= 1'b0;
                        if (rw_r) begin
                            state <= ST_IDE_ACK;
                        end else begin
                            IDE_DIOW_n <= 1'b1;
                            cnt        <= HOLD_LD;
                            state      <= ST_IDE_HOLD;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_IDE_ACK: begin
                    // DIOR_n stays low so read data is valid while the CPU samples it.
                    if (as_s) begin
                        IDE_DIOR_n <= 1'b1;
                        DTACK_n    <= 1'b1;
                        cnt        <= HOLD_LD;
                        state      <= ST_IDE_HOLD;
                    end
                end
                ST_IDE_HOLD: begin
                    if (as_s)
                        DTACK_n <= 1'b1;
                    if (cnt == 4'd0) begin
                        IDE_CS0_n    <= 1'b1;
                        IDE_CS1_n    <= 1'b1;
                        IDE_BUF_OE_n <= 1'b1;
                        IDE_BUF_DIR  <= 1'b1;
                        // Only an acknowledged cycle still owned by the CPU waits for AS;
                        // a low AS with DTACK released is already the next cycle.
                        state <= (!as_s && !DTACK_n) ? ST_WAIT_END : ST_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_WAIT_END: begin
                    if (as_s) begin
                        DTACK_n  <= 1'b1;
                        ROM_OE_n <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zii_ide_cycle_ctrl.sv
// Directed bench for zii_ide_cycle_ctrl: three instances (default, all-1 and
// all-15 timing) share the CPU bus; only the selected one is configured.
module tb_zii_ide_cycle_ctrl;
    import zii_ide_pkg::*;

    localparam int NI = 3;
    localparam int SETUPV  [NI] = '{2, 1, 15};
    localparam int STROBEV [NI] = '{5, 1, 15};
    localparam int HOLDV   [NI] = '{1, 1, 15};
    localparam int ROMV    [NI] = '{3, 1, 15};

    localparam int K_CS = 0, K_RD = 1, K_WR = 2, K_DTK = 3, K_ROM = 4, K_BOE = 5;

    logic        clk = 1'b0;
    logic        RESET_n;
    logic        AS_n, DS_n, RW_n;
    logic [23:1] A;
    logic [7:0]  base;
    logic        cfg_n;
    int          sel;
    int          cyc = 0;

    logic [NI-1:0] dtack_v, rom_v, cs0_v, cs1_v, dior_v, diow_v, bufoe_v, dir_v;
    logic [2:0]    da_v [NI];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        logic       cfg_g;
        logic [5:0] s;
        logic [5:0] prev = '1;
        logic [2:0] da_prev = 3'd0;
        int         tf [6] = '{default: -1};
        int         tr [6] = '{default: -1};
        int         toggles = 0;
        logic [5:0] cap = '0;

        assign cfg_g = (sel == g) ? cfg_n : 1'b1;
        assign s = {bufoe_v[g], rom_v[g], dtack_v[g], diow_v[g], dior_v[g], cs0_v[g] & cs1_v[g]};

        zii_ide_cycle_ctrl #(
            .SETUP_CLKS(SETUPV[g]), .STROBE_CLKS(STROBEV[g]),
            .HOLD_CLKS(HOLDV[g]),   .ROM_WAIT_CLKS(ROMV[g])
        ) u_dut (
            .CLK(clk), .RESET_n(RESET_n), .AS_CPU_n(AS_n), .DS_n(DS_n), .RW_n(RW_n),
            .A(A), .BASE_IDE(base), .IDE_CONFIGURED_n(cfg_g),
            .DTACK_n(dtack_v[g]), .ROM_OE_n(rom_v[g]), .IDE_CS0_n(cs0_v[g]),
            .IDE_CS1_n(cs1_v[g]), .IDE_DA(da_v[g]), .IDE_DIOR_n(dior_v[g]),
            .IDE_DIOW_n(diow_v[g]), .IDE_BUF_OE_n(bufoe_v[g]), .IDE_BUF_DIR(dir_v[g])
        );

        // Edge timestamps (in clock counts) of every strobe, sampled after each edge.
        always @(posedge clk) begin
            #1;
            if (s != prev || da_v[g] != da_prev) toggles++;
            for (int k = 0; k < 6; k++) begin
                if (prev[k] && !s[k]) tf[k] = cyc;
                if (!prev[k] && s[k]) tr[k] = cyc;
            end
            if (prev[0] && !s[0]) cap = {cs0_v[g], cs1_v[g], da_v[g], dir_v[g]};
            prev    = s;
            da_prev = da_v[g];
        end
    end

    function automatic int get_tf(input int i, input int k);
        case (i)
            0:       return g_inst[0].tf[k];
            1:       return g_inst[1].tf[k];
            default: return g_inst[2].tf[k];
        endcase
    endfunction

    function automatic int get_tr(input int i, input int k);
        case (i)
            0:       return g_inst[0].tr[k];
            1:       return g_inst[1].tr[k];
            default: return g_inst[2].tr[k];
        endcase
    endfunction

    function automatic int get_tog(input int i);
        case (i)
            0:       return g_inst[0].toggles;
            1:       return g_inst[1].toggles;
            default: return g_inst[2].toggles;
        endcase
    endfunction

    function automatic logic [5:0] get_cap(input int i);
        case (i)
            0:       return g_inst[0].cap;
            1:       return g_inst[1].cap;
            default: return g_inst[2].cap;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_idle(input string name, input int i);
        chk({name, ".dtack"}, dtack_v[i], 1);
        chk({name, ".rom_oe"}, rom_v[i], 1);
        chk({name, ".cs0"}, cs0_v[i], 1);
        chk({name, ".cs1"}, cs1_v[i], 1);
        chk({name, ".dior"}, dior_v[i], 1);
        chk({name, ".diow"}, diow_v[i], 1);
        chk({name, ".buf_oe"}, bufoe_v[i], 1);
        chk({name, ".buf_dir"}, dir_v[i], 1);
        chk({name, ".da"}, da_v[i], 0);
    endtask

    task automatic wait_dtack(input int i, input logic lvl, input int bound, output logic got);
        got = 1'b0;
        for (int n = 0; n < bound && !got; n++) begin
            @(posedge clk); #2;
            if (dtack_v[i] == lvl) got = 1'b1;
        end
    endtask

    task automatic cpu_cycle(input logic [23:0] addr, input logic rw, input int i, output logic got);
        @(negedge clk);
        A = addr[23:1]; RW_n = rw; AS_n = 1'b0; DS_n = 1'b0;
        wait_dtack(i, 1'b0, 60, got);
        @(posedge clk);
        @(negedge clk);
        AS_n = 1'b1; DS_n = 1'b1;
        repeat (25) @(posedge clk);
    endtask

    typedef struct {
        logic [23:0] addr;
        logic        rw;
        logic        cfg_n;
        logic [7:0]  base;
        int          inst;
        logic        ack;
        logic        rom;
        logic        cs0;
        logic        cs1;
        logic [2:0]  da;
        logic        dir;
    } vec_t;

    function automatic vec_t mk(input logic [23:0] a, input logic rw, input logic c,
                                input logic [7:0] b, input int i, input logic ack,
                                input logic rom, input logic cs0, input logic cs1,
                                input logic [2:0] da, input logic dir);
        vec_t v;
        v.addr = a; v.rw = rw; v.cfg_n = c; v.base = b; v.inst = i; v.ack = ack;
        v.rom = rom; v.cs0 = cs0; v.cs1 = cs1; v.da = da; v.dir = dir;
        return v;
    endfunction

    initial begin
        vec_t  vecs[$];
        logic  got, got2;
        int    t0, tog0, i, ks;
        string nm;

        //                addr       rw  cfg  base  inst ack rom cs0 cs1 da  dir
        vecs.push_back(mk(24'hE98004, 1, 0, 8'hE9, 0, 1, 0, 0, 1, 3'd1, 1));
        vecs.push_back(mk(24'hE99018, 0, 0, 8'hE9, 0, 1, 0, 1, 0, 3'd6, 0));
        vecs.push_back(mk(24'hE90010, 1, 0, 8'hE9, 0, 1, 1, 1, 1, 3'd0, 1));
        vecs.push_back(mk(24'hE90010, 0, 0, 8'hE9, 0, 1, 1, 1, 1, 3'd0, 1));
        vecs.push_back(mk(24'hE98004, 1, 1, 8'hE9, 0, 0, 0, 1, 1, 3'd0, 1));
        vecs.push_back(mk(24'hEA8000, 1, 0, 8'hE9, 0, 0, 0, 1, 1, 3'd0, 1));
        vecs.push_back(mk(24'hE9E01C, 1, 0, 8'hE9, 0, 1, 0, 0, 1, 3'd7, 1));
        vecs.push_back(mk(24'h20A008, 0, 0, 8'h20, 0, 1, 0, 0, 1, 3'd2, 0));
        vecs.push_back(mk(24'hE98004, 1, 0, 8'hE9, 1, 1, 0, 0, 1, 3'd1, 1));
        vecs.push_back(mk(24'hE99018, 0, 0, 8'hE9, 1, 1, 0, 1, 0, 3'd6, 0));
        vecs.push_back(mk(24'hE90010, 1, 0, 8'hE9, 1, 1, 1, 1, 1, 3'd0, 1));
        vecs.push_back(mk(24'hE98004, 1, 0, 8'hE9, 2, 1, 0, 0, 1, 3'd1, 1));
        vecs.push_back(mk(24'hE99018, 0, 0, 8'hE9, 2, 1, 0, 1, 0, 3'd6, 0));
        vecs.push_back(mk(24'hE90010, 1, 0, 8'hE9, 2, 1, 1, 1, 1, 3'd0, 1));

        RESET_n = 1'b0; AS_n = 1'b1; DS_n = 1'b1; RW_n = 1'b1; A = '0;
        base = 8'hE9; cfg_n = 1'b0; sel = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int n = 0; n < NI; n++) chk_idle($sformatf("reset%0d", n), n);
        @(negedge clk);
        RESET_n = 1'b1;
        repeat (3) @(posedge clk);

        for (int v = 0; v < vecs.size(); v++) begin
            i = vecs[v].inst; base = vecs[v].base; cfg_n = vecs[v].cfg_n; sel = i;
            nm = $sformatf("v%0d", v);
            t0 = cyc; tog0 = get_tog(i);
            cpu_cycle(vecs[v].addr, vecs[v].rw, i, got);
            chk({nm, ".ack"}, got, vecs[v].ack);
            if (!vecs[v].ack) begin
                chk({nm, ".no_toggle"}, get_tog(i) - tog0, 0);
            end else if (vecs[v].rom) begin
                if (vecs[v].rw) begin
                    chk({nm, ".rom_oe_low"}, get_tf(i, K_ROM) > t0, 1);
                    chk({nm, ".rom_wait"}, get_tf(i, K_DTK) - get_tf(i, K_ROM), ROMV[i]);
                    chk({nm, ".rom_release"}, get_tr(i, K_ROM), get_tr(i, K_DTK));
                end else begin
                    chk({nm, ".rom_oe_quiet"}, get_tf(i, K_ROM) > t0, 0);
                end
            end else begin
                chk({nm, ".cs_sel"}, get_cap(i), {vecs[v].cs0, vecs[v].cs1, vecs[v].da, vecs[v].dir});
                ks = vecs[v].rw ? K_RD : K_WR;
                chk({nm, ".setup"}, get_tf(i, ks) - get_tf(i, K_CS), SETUPV[i]);
                chk({nm, ".buf_oe"}, get_tf(i, K_BOE), get_tf(i, K_CS));
                if (vecs[v].rw) begin
                    chk({nm, ".strobe_to_dtack"}, get_tf(i, K_DTK) - get_tf(i, K_RD), STROBEV[i]);
                    chk({nm, ".dior_release"}, get_tr(i, K_RD), get_tr(i, K_DTK));
                    chk({nm, ".hold"}, get_tr(i, K_CS) - get_tr(i, K_RD), HOLDV[i]);
                end else begin
                    chk({nm, ".diow_width"}, get_tr(i, K_WR) - get_tf(i, K_WR), STROBEV[i]);
                    chk({nm, ".dtack_at_hold"}, get_tf(i, K_DTK), get_tr(i, K_WR));
                    chk({nm, ".hold"}, get_tr(i, K_CS) - get_tr(i, K_WR), HOLDV[i]);
                end
            end
        end

        // AS withdrawn two clocks into the write strobe
        sel = 0; base = 8'hE9; cfg_n = 1'b0; t0 = cyc;
        @(negedge clk);
        A = 23'(24'hE99018 >> 1); RW_n = 1'b0; AS_n = 1'b0; DS_n = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        AS_n = 1'b1; DS_n = 1'b1;
        repeat (25) @(posedge clk);
        chk("abort.diow_low", get_tf(0, K_WR) > t0, 1);
        chk("abort.diow_width", get_tr(0, K_WR) - get_tf(0, K_WR), 2);
        chk("abort.cs_hold", get_tr(0, K_CS) - get_tr(0, K_WR), 1);
        chk("abort.no_dtack", get_tf(0, K_DTK) > t0, 0);

        // Asynchronous reset in the middle of a write strobe
        @(negedge clk);
        A = 23'(24'hE99018 >> 1); RW_n = 1'b0; AS_n = 1'b0; DS_n = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(posedge clk); #1;
            if (!diow_v[0]) got = 1'b1;
        end
        chk("rst.reached_strobe", got, 1);
        #1 RESET_n = 1'b0;
        #1;
        chk_idle("rst_mid", 0);
        chk("rst_mid.state", int'(g_inst[0].u_dut.state), int'(ST_IDLE));
        @(negedge clk);
        AS_n = 1'b1; DS_n = 1'b1;
        @(negedge clk);
        RESET_n = 1'b1;
        repeat (3) @(posedge clk);
        cpu_cycle(24'hE98004, 1'b1, 0, got);
        chk("rst.recover_ack", got, 1);

        // Back-to-back reads: the second starts as soon as the first DTACK drops
        for (int n = 1; n < NI; n++) begin
            sel = n; cfg_n = 1'b0; base = 8'hE9;
            @(negedge clk);
            A = 23'(24'hE98004 >> 1); RW_n = 1'b1; AS_n = 1'b0; DS_n = 1'b0;
            wait_dtack(n, 1'b0, 60, got);
            @(negedge clk);
            AS_n = 1'b1; DS_n = 1'b1;
            wait_dtack(n, 1'b1, 20, got2);
            chk($sformatf("b2b%0d.release", n), got2, 1);
            @(negedge clk);
            AS_n = 1'b0; DS_n = 1'b0;
            wait_dtack(n, 1'b0, 80, got2);
            @(negedge clk);
            AS_n = 1'b1; DS_n = 1'b1;
            repeat (25) @(posedge clk);
            chk($sformatf("b2b%0d.first_ack", n), got, 1);
            chk($sformatf("b2b%0d.second_ack", n), got2, 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
